// File: rtl/tetris_sched_pkg.sv
// Shared encodings for the piece move scheduler: command opcodes, FSM states and timer width.
// Build option: PIECE_LOCK_DELAY_EN adds the LOCKWAIT state (lock delay counted in gravity ticks).
package tetris_sched_pkg;

    localparam int TIMER_W = 24;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_LEFT   = 3'd1,
        OP_RIGHT  = 3'd2,
        OP_ROTATE = 3'd3,
        OP_DOWN   = 3'd4,
        OP_LOCK   = 3'd5,
        OP_SPAWN  = 3'd6
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_SPAWN    = 3'd0,
        ST_RUN      = 3'd1,
        ST_ISSUE    = 3'd2,
`ifdef PIECE_LOCK_DELAY_EN
        ST_LOCKWAIT = 3'd3,
`endif
        ST_LOCK     = 3'd4,
        ST_HALT     = 3'd5
    } state_e;

    // Saturating period: never wraps below MIN_PERIOD even when level*step exceeds base.
    function automatic logic [TIMER_W-1:0] grav_period(
        input logic [3:0]         level,
        input logic [TIMER_W-1:0] base,
        input logic [TIMER_W-1:0] step,
        input logic [TIMER_W-1:0] min_p
    );
        logic [TIMER_W+3:0] dec;
        logic [TIMER_W+3:0] base_x;
        dec    = {4'd0, step} * {{TIMER_W{1'b0}}, level};
        base_x = {4'd0, base};
        if ((base_x > dec) && ((base_x - dec) > {4'd0, min_p}))
            return base - dec[TIMER_W-1:0];
        else
            return min_p;
    endfunction

endpackage

// File: rtl/gravity_timer.sv
// Level-scaled gravity down-counter: counts period-1..0, pulses o_tick at 0 and reloads.
// Frozen by i_freeze; i_reload (soft drop) restarts the period without an extra tick.
module gravity_timer
    import tetris_sched_pkg::*;
#(
    parameter logic [TIMER_W-1:0] BASE_PERIOD = 24'd5_000_000,
    parameter logic [TIMER_W-1:0] LEVEL_STEP  = 24'd400_000,
    parameter logic [TIMER_W-1:0] MIN_PERIOD  = 24'd500_000
)(
    input  logic       clock,
    input  logic       resetn,
    input  logic [3:0] i_level,
    input  logic       i_freeze,
    input  logic       i_reload,
    output logic       o_tick
);

    localparam logic [TIMER_W-1:0] RESET_PERIOD =
        grav_period(4'd0, BASE_PERIOD, LEVEL_STEP, MIN_PERIOD);
    localparam logic [TIMER_W-1:0] RESET_LOAD =
        (RESET_PERIOD == '0) ? '0 : RESET_PERIOD - 24'd1;

    logic [TIMER_W-1:0] r_count;
    logic [TIMER_W-1:0] w_period;
    logic [TIMER_W-1:0] w_reload_val;
    logic               w_tick;

    assign w_period     = grav_period(i_level, BASE_PERIOD, LEVEL_STEP, MIN_PERIOD);
    assign w_reload_val = (w_period == '0) ? '0 : w_period - 24'd1;
    assign w_tick       = ~i_freeze & (r_count == '0);
    assign o_tick       = w_tick;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_count <= RESET_LOAD;
        end else if (!i_freeze) begin
            if (w_tick || i_reload)
                r_count <= w_reload_val;
            else
                r_count <= r_count - 24'd1;
        end
    end

endmodule

// File: rtl/piece_move_scheduler.sv
// Merges move/rotate/drop/gravity requests into one valid/ready command stream and runs the
// piece lifecycle (spawn, move, lock, respawn, halt). Build option: PIECE_LOCK_DELAY_EN.
module piece_move_scheduler
    import tetris_sched_pkg::*;
#(
    parameter logic [TIMER_W-1:0] BASE_PERIOD = 24'd5_000_000,
    parameter logic [TIMER_W-1:0] LEVEL_STEP  = 24'd400_000,
    parameter logic [TIMER_W-1:0] MIN_PERIOD  = 24'd500_000,
    parameter logic [1:0]         LOCK_TICKS  = 2'd2
)(
    input  logic       clock,
    input  logic       resetn,
    input  logic       left_req,
    input  logic       right_req,
    input  logic       rotate_req,
    input  logic       drop_req,
    input  logic [3:0] level,
    input  logic       pause,
    input  logic       game_over,
    input  logic       cmd_ready,
    input  logic       cmd_blocked,
    output logic       cmd_valid,
    output logic [2:0] cmd_op,
    output logic       grav_tick,
    output logic       halted
);

    state_e  r_state;
    state_e  w_next_state;
    cmd_op_e r_op;
    cmd_op_e w_pick_op;
    cmd_op_e w_cmd_op;
    logic    r_started;
    logic    r_pend_l, r_pend_r, r_pend_rot, r_pend_dn;
    logic    w_accept, w_left, w_right, w_rot, w_drop;
    logic    w_tick, w_freeze, w_xfer, w_cmd_valid;
    logic    w_serve, w_lr_cancel, w_pick_valid, w_start;
    logic    w_done, w_clear_all;

    // Requests are dropped, not deferred, while paused or halted.
    assign w_accept = ~pause & (r_state != ST_HALT);
    assign w_left   = left_req   & w_accept;
    assign w_right  = right_req  & w_accept;
    assign w_rot    = rotate_req & w_accept;
    assign w_drop   = drop_req   & w_accept;
    assign w_freeze = pause | (r_state == ST_HALT);
    assign w_xfer   = w_cmd_valid & cmd_ready;

`ifdef PIECE_LOCK_DELAY_EN
    logic       r_lw_active;
    logic       r_lw_drop;
    logic [1:0] r_lw_ticks;
    assign w_serve = ~pause & ((r_state == ST_RUN) || (r_state == ST_LOCKWAIT));
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^LOCK_TICKS;
    assign w_serve      = ~pause & (r_state == ST_RUN);
`endif

    assign w_lr_cancel = w_serve & r_pend_l & r_pend_r;
    assign w_done      = w_xfer & (r_state == ST_ISSUE);
    assign w_clear_all = w_xfer & (r_state == ST_LOCK);
    assign w_start     = (w_next_state == ST_ISSUE) && (r_state != ST_ISSUE);

    gravity_timer #(
        .BASE_PERIOD (BASE_PERIOD),
        .LEVEL_STEP  (LEVEL_STEP),
        .MIN_PERIOD  (MIN_PERIOD)
    ) u_gravity_timer (
        .clock    (clock),
        .resetn   (resetn),
        .i_level  (level),
        .i_freeze (w_freeze),
        .i_reload (w_drop),
        .o_tick   (w_tick)
    );

    // DOWN is only eligible from RUN; a simultaneous LEFT+RIGHT pair cancels out.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_pick_valid = 1'b1;
        w_pick_op    = OP_NOP;
        if (r_pend_dn && (r_state == ST_RUN))
            w_pick_op = OP_DOWN;
        else if (r_pend_rot)
            w_pick_op = OP_ROTATE;
        else if (r_pend_l && !r_pend_r)
            w_pick_op = OP_LEFT;
        else if (r_pend_r && !r_pend_l)
            w_pick_op = OP_RIGHT;
        else
            w_pick_valid = 1'b0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            r_state <= ST_SPAWN;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_SPAWN: if (w_xfer) w_next_state = game_over ? ST_HALT : ST_RUN;
            ST_RUN:   if (w_serve && w_pick_valid) w_next_state = ST_ISSUE;
            ST_ISSUE: begin
                if (w_xfer) begin
`ifdef PIECE_LOCK_DELAY_EN
                    if ((r_op == OP_DOWN) && cmd_blocked)
                        w_next_state = ST_LOCKWAIT;
                    else
                        w_next_state = r_lw_active ? ST_LOCKWAIT : ST_RUN;
`else
                    if ((r_op == OP_DOWN) && cmd_blocked)
                        w_next_state = ST_LOCK;
                    else
                        w_next_state = ST_RUN;
`endif
                end
            end
`ifdef PIECE_LOCK_DELAY_EN
            ST_LOCKWAIT: begin
                if ((r_lw_ticks >= LOCK_TICKS) || r_lw_drop || w_drop)
                    w_next_state = ST_LOCK;
                else if (w_serve && w_pick_valid)
                    w_next_state = ST_ISSUE;
            end
`endif
            ST_LOCK:  if (w_xfer) w_next_state = ST_SPAWN;
            ST_HALT:  w_next_state = ST_HALT;
            default:  w_next_state = ST_SPAWN;
        endcase
    end

    // r_started keeps cmd_valid low until the first edge after reset release.
    always_comb begin
        w_cmd_valid = 1'b0;
        w_cmd_op    = OP_NOP;
        halted      = 1'b0;
        case (r_state)
            ST_SPAWN: begin
                w_cmd_valid = r_started;
                w_cmd_op    = r_started ? OP_SPAWN : OP_NOP;
            end
            ST_ISSUE: begin
                w_cmd_valid = 1'b1;
                w_cmd_op    = r_op;
            end
            ST_LOCK: begin
                w_cmd_valid = 1'b1;
                w_cmd_op    = OP_LOCK;
            end
            ST_HALT:  halted = 1'b1;
            default:  ;
        endcase
    end

    assign cmd_valid = w_cmd_valid;
    assign cmd_op    = w_cmd_op;
    assign grav_tick = w_tick;

    // A new request in a transfer cycle wins over that transfer's flag clear.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_started  <= 1'b0;
            r_op       <= OP_NOP;
            r_pend_l   <= 1'b0;
            r_pend_r   <= 1'b0;
            r_pend_rot <= 1'b0;
            r_pend_dn  <= 1'b0;
        end else begin
            r_started <= 1'b1;
            if (w_start)
                r_op <= w_pick_op;
            if (w_clear_all) begin
                r_pend_l   <= 1'b0;
                r_pend_r   <= 1'b0;
                r_pend_rot <= 1'b0;
                r_pend_dn  <= 1'b0;
            end else begin
                r_pend_l   <= w_left  | (r_pend_l & ~w_lr_cancel & ~(w_done && (r_op == OP_LEFT)));
                r_pend_r   <= w_right | (r_pend_r & ~w_lr_cancel & ~(w_done && (r_op == OP_RIGHT)));
                r_pend_rot <= w_rot   | (r_pend_rot & ~(w_done && (r_op == OP_ROTATE)));
                r_pend_dn  <= w_drop  | w_tick | (r_pend_dn & ~(w_done && (r_op == OP_DOWN)));
            end
        end
    end

`ifdef PIECE_LOCK_DELAY_EN
    // Lock-delay bookkeeping spans LOCKWAIT and any side-move ISSUE served from it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_lw_active <= 1'b0;
            r_lw_drop   <= 1'b0;
            r_lw_ticks  <= 2'd0;
        end else if ((w_next_state == ST_LOCKWAIT) && (r_state == ST_ISSUE) && !r_lw_active) begin
            r_lw_active <= 1'b1;
            r_lw_drop   <= 1'b0;
            r_lw_ticks  <= 2'd0;
        end else if (r_lw_active) begin
            if (w_next_state == ST_LOCK)
                r_lw_active <= 1'b0;
            if (w_tick && (r_lw_ticks != 2'd3))
                r_lw_ticks <= r_lw_ticks + 2'd1;
            if (w_drop)
                r_lw_drop <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_piece_move_scheduler.sv
// Self-checking bench for piece_move_scheduler: directed lifecycle scenarios plus a randomized
// run checked cycle by cycle against a behavioural model of the command rules.
module tb_piece_move_scheduler;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       left_req, right_req, rotate_req, drop_req;
    logic [3:0] level;
    logic       pause, game_over, cmd_ready, cmd_blocked;
    logic       cmd_valid;
    logic [2:0] cmd_op;
    logic       grav_tick;
    logic       halted;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    piece_move_scheduler #(
        .BASE_PERIOD (24'd100),
        .LEVEL_STEP  (24'd10),
        .MIN_PERIOD  (24'd20),
        .LOCK_TICKS  (2'd2)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .left_req    (left_req),
        .right_req   (right_req),
        .rotate_req  (rotate_req),
        .drop_req    (drop_req),
        .level       (level),
        .pause       (pause),
        .game_over   (game_over),
        .cmd_ready   (cmd_ready),
        .cmd_blocked (cmd_blocked),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .grav_tick   (grav_tick),
        .halted      (halted)
    );

    function automatic int period_of(input int lvl);
        int p;
        p = 100 - lvl * 10;
        return (p < 20) ? 20 : p;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        left_req = 0; right_req = 0; rotate_req = 0; drop_req = 0;
        level = 4'd0; pause = 0; game_over = 0; cmd_ready = 0; cmd_blocked = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    // Leaves the DUT in RUN right after the SPAWN transfer, with cmd_ready held high.
    task automatic spawn_run();
        cmd_ready = 1'b1;
        step();
        step();
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!grav_tick && n < 300);
        if (!grav_tick) begin
            n_tests++; n_fail++;
            $display("FAIL tick_timeout: no grav_tick within %0d cycles", n);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn = 1'b0;
        step();
        step();
        n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", cmd_valid); end
        n_tests++; if (cmd_op !== 3'd0) begin n_fail++; $display("FAIL reset_op: got %0d want 0", cmd_op); end
        n_tests++; if (grav_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", grav_tick); end
        n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
        resetn = 1'b1;
        #1;
        n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL release_valid: got %b want 0", cmd_valid); end
        step();
        n_tests++; if (cmd_valid !== 1'b1 || cmd_op !== 3'd6) begin n_fail++; $display("FAIL first_spawn: got v=%b op=%0d want v=1 op=6", cmd_valid, cmd_op); end
        begin
            int bad = 0;
            for (int i = 0; i < 3; i++) begin
                step();
                if (cmd_valid !== 1'b1 || cmd_op !== 3'd6) bad++;
            end
            n_tests++; if (bad != 0) begin n_fail++; $display("FAIL spawn_hold: %0d unstable cycles want 0", bad); end
        end
        cmd_ready = 1'b1;
        step();
        n_tests++; if (cmd_valid !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL spawn_to_run: got v=%b h=%b want v=0 h=0", cmd_valid, halted); end
    endtask

    task automatic test_lr_cancel();
        int seen;
        do_reset();
        spawn_run();
        left_req = 1; right_req = 1;
        step();
        left_req = 0; right_req = 0;
        seen = 0;
        repeat (6) begin
            if (cmd_valid) seen++;
            step();
        end
        n_tests++; if (seen != 0) begin n_fail++; $display("FAIL lr_cancel: got %0d valid cycles want 0", seen); end
        left_req = 1;
        step();
        left_req = 0;
        n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL left_lat1: got v=%b want 0", cmd_valid); end
        step();
        n_tests++; if (cmd_valid !== 1'b1 || cmd_op !== 3'd1) begin n_fail++; $display("FAIL left_lat2: got v=%b op=%0d want v=1 op=1", cmd_valid, cmd_op); end
        seen = 0;
        repeat (5) begin
            step();
            if (cmd_valid) seen++;
        end
        n_tests++; if (seen != 0) begin n_fail++; $display("FAIL lr_flags_clear: got %0d extra valid cycles want 0", seen); end
    endtask

    task automatic test_priority_hold();
        int bad;
        do_reset();
        spawn_run();
        cmd_ready = 0;
        rotate_req = 1; drop_req = 1;
        step();
        rotate_req = 0; drop_req = 0;
        step();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (cmd_valid !== 1'b1 || cmd_op !== 3'd4) bad++;
            if (i < 4) step();
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL down_hold: %0d cycles not DOWN/valid want 0", bad); end
        cmd_ready = 1;
        step();
        n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL after_down: got v=%b want 0", cmd_valid); end
        step();
        n_tests++; if (cmd_valid !== 1'b1 || cmd_op !== 3'd3) begin n_fail++; $display("FAIL rotate_next: got v=%b op=%0d want v=1 op=3", cmd_valid, cmd_op); end
        step();
        n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rotate_done: got v=%b want 0", cmd_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        spawn_run();
        left_req = 1;
        step();
        left_req = 0;
        step();
        n_tests++; if (cmd_valid !== 1'b1 || cmd_op !== 3'd1) begin n_fail++; $display("FAIL b2b_first: got v=%b op=%0d want v=1 op=1", cmd_valid, cmd_op); end
        left_req = 1;
        step();
        left_req = 0;
        n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got v=%b want 0", cmd_valid); end
        step();
        n_tests++; if (cmd_valid !== 1'b1 || cmd_op !== 3'd1) begin n_fail++; $display("FAIL b2b_second: got v=%b op=%0d want v=1 op=1", cmd_valid, cmd_op); end
        step();
        step();
        n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_third: got v=%b want 0", cmd_valid); end
        rotate_req = 1;
        step();
        rotate_req = 0;
        cmd_ready = 0;
        step();
        #2 resetn = 1'b0;
        #1;
        n_tests++; if (cmd_valid !== 1'b0 || cmd_op !== 3'd0) begin n_fail++; $display("FAIL async_reset: got v=%b op=%0d want v=0 op=0", cmd_valid, cmd_op); end
    endtask

    task automatic test_gravity_period();
        int n;
        do_reset();
        spawn_run();
        level = 4'd15;
        wait_tick(n);
        wait_tick(n);
        n_tests++; if (n != 20) begin n_fail++; $display("FAIL period_l15a: got %0d want 20", n); end
        wait_tick(n);
        n_tests++; if (n != 20) begin n_fail++; $display("FAIL period_l15b: got %0d want 20", n); end
        level = 4'd3;
        wait_tick(n);
        n_tests++; if (n != period_of(3)) begin n_fail++; $display("FAIL period_l3a: got %0d want %0d", n, period_of(3)); end
        wait_tick(n);
        n_tests++; if (n != period_of(3)) begin n_fail++; $display("FAIL period_l3b: got %0d want %0d", n, period_of(3)); end
    endtask

    task automatic test_lock_spawn();
        do_reset();
        spawn_run();
        cmd_blocked = 1;
`ifdef PIECE_LOCK_DELAY_EN
        begin
            int nt, cyc;
            level = 4'd15;
            drop_req = 1;
            step();
            drop_req = 0;
            step();
            n_tests++; if (cmd_valid !== 1'b1 || cmd_op !== 3'd4) begin n_fail++; $display("FAIL lw_down: got v=%b op=%0d want v=1 op=4", cmd_valid, cmd_op); end
            step();
            n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL lw_wait: got v=%b want 0", cmd_valid); end
            left_req = 1;
            step();
            left_req = 0;
            step();
            n_tests++; if (cmd_valid !== 1'b1 || cmd_op !== 3'd1) begin n_fail++; $display("FAIL lw_left: got v=%b op=%0d want v=1 op=1", cmd_valid, cmd_op); end
            nt = 0; cyc = 0;
            while (!(cmd_valid === 1'b1 && cmd_op === 3'd5) && cyc < 200) begin
                if (grav_tick) nt++;
                step();
                cyc++;
            end
            n_tests++; if (cyc >= 200 || nt != 2) begin n_fail++; $display("FAIL lw_ticks: got %0d ticks before LOCK (cyc %0d) want 2", nt, cyc); end
        end
`else
        drop_req = 1;
        step();
        drop_req = 0;
        step();
        n_tests++; if (cmd_valid !== 1'b1 || cmd_op !== 3'd4) begin n_fail++; $display("FAIL blk_down: got v=%b op=%0d want v=1 op=4", cmd_valid, cmd_op); end
        step();
        n_tests++; if (cmd_valid !== 1'b1 || cmd_op !== 3'd5) begin n_fail++; $display("FAIL lock: got v=%b op=%0d want v=1 op=5", cmd_valid, cmd_op); end
`endif
        cmd_blocked = 0;
        step();
        n_tests++; if (cmd_valid !== 1'b1 || cmd_op !== 3'd6) begin n_fail++; $display("FAIL respawn: got v=%b op=%0d want v=1 op=6", cmd_valid, cmd_op); end
        step();
        n_tests++; if (cmd_valid !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL respawn_run: got v=%b h=%b want v=0 h=0", cmd_valid, halted); end
    endtask

    task automatic test_halt();
        int sv, st;
        do_reset();
        game_over = 1;
        cmd_ready = 1;
        step();
        step();
        game_over = 0;
        n_tests++; if (halted !== 1'b1 || cmd_valid !== 1'b0) begin n_fail++; $display("FAIL halt_enter: got h=%b v=%b want h=1 v=0", halted, cmd_valid); end
        sv = 0; st = 0;
        for (int i = 0; i < 250; i++) begin
            left_req   = ($urandom_range(0, 3) == 0);
            rotate_req = ($urandom_range(0, 3) == 0);
            drop_req   = ($urandom_range(0, 7) == 0);
            step();
            if (cmd_valid) sv++;
            if (grav_tick) st++;
        end
        clear_inputs();
        n_tests++; if (sv != 0) begin n_fail++; $display("FAIL halt_valid: got %0d valid cycles want 0", sv); end
        n_tests++; if (st != 0) begin n_fail++; $display("FAIL halt_ticks: got %0d ticks want 0", st); end
        n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_stays: got %b want 1", halted); end
    endtask

    // Model: mode 0 spawning, 1 idle in RUN, 2 offering a command; pend[op] holds merged requests.
    task automatic test_random();
        int       m_mode, m_op, m_cnt, shown, e_op;
        bit       m_started, e_valid, e_tick, xfer, acc;
        bit [4:0] m_pend;
        do_reset();
        m_mode = 0; m_op = 0; m_cnt = period_of(0) - 1; m_started = 0; m_pend = '0; shown = 0;
        for (int c = 0; c < 3000; c++) begin
            left_req   = ($urandom_range(0, 9) == 0);
            right_req  = ($urandom_range(0, 9) == 0);
            rotate_req = ($urandom_range(0, 9) == 0);
            drop_req   = ($urandom_range(0, 29) == 0);
            pause      = ($urandom_range(0, 19) == 0);
            cmd_ready  = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 49) == 0) level = 4'($urandom_range(0, 15));
            #1;
            e_valid = m_started && (m_mode != 1);
            e_op    = !e_valid ? 0 : ((m_mode == 0) ? 6 : m_op);
            e_tick  = (m_cnt == 0) && !pause;
            n_tests++;
            if (cmd_valid !== e_valid || cmd_op !== 3'(e_op) || grav_tick !== e_tick) begin
                n_fail++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL rand_c%0d: got v=%b op=%0d t=%b want v=%b op=%0d t=%b",
                             c, cmd_valid, cmd_op, grav_tick, e_valid, e_op, e_tick);
                end
            end
            @(posedge clock);
            xfer = e_valid && cmd_ready;
            acc  = !pause;
            if (m_mode == 0) begin
                if (xfer) m_mode = 1;
            end else if (m_mode == 2) begin
                if (xfer) begin m_pend[m_op] = 1'b0; m_mode = 1; end
            end else if (acc) begin
                if (m_pend[1] && m_pend[2]) begin m_pend[1] = 1'b0; m_pend[2] = 1'b0; end
                if (m_pend[4])      begin m_op = 4; m_mode = 2; end
                else if (m_pend[3]) begin m_op = 3; m_mode = 2; end
                else if (m_pend[1]) begin m_op = 1; m_mode = 2; end
                else if (m_pend[2]) begin m_op = 2; m_mode = 2; end
            end
            if (acc) begin
                m_pend[1] = m_pend[1] | left_req;
                m_pend[2] = m_pend[2] | right_req;
                m_pend[3] = m_pend[3] | rotate_req;
                m_pend[4] = m_pend[4] | drop_req | e_tick;
            end
            if (!pause) m_cnt = (e_tick || drop_req) ? period_of(int'(level)) - 1 : m_cnt - 1;
            m_started = 1;
            #1;
        end
        clear_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        #1;
        test_reset();
        test_lr_cancel();
        test_priority_hold();
        test_back_to_back();
        test_gravity_period();
        test_lock_spawn();
        test_halt();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
